// File: rtl/reg_bank_pkg.sv
// Constants and types shared by the register bank and the blocks that read it over port B.
package reg_bank_pkg;

  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned NUM_REGS = 16;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain
  } scanStateE;

endpackage

// File: rtl/reg_bank_out_fifo.sv
// Synchronous FIFO with registered read data and an occupancy count.
// A push into a full FIFO is only accepted together with a pop; a pop from an empty FIFO is ignored.
module reg_bank_out_fifo #(
  parameter int unsigned Width = 12,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned OccW = PtrW + 1
) (
  input  logic             clkI,
  input  logic             rstNI,
  input  logic             pushI,
  input  logic [Width-1:0] pushDataI,
  input  logic             popI,
  output logic [Width-1:0] popDataO,
  output logic             emptyO,
  output logic [OccW-1:0]  occupancyO
);

  logic [Width-1:0] memQ [Depth];
  logic [PtrW-1:0]  wrPtrQ, rdPtrQ;
  logic [OccW-1:0]  occQ;
  logic             full;
  logic             wrEn, rdEn;

  assign emptyO     = (occQ == '0);
  assign full       = (occQ == OccW'(Depth));
  assign rdEn       = popI && !emptyO;
  assign wrEn       = pushI && (!full || rdEn);
  assign popDataO   = memQ[rdPtrQ];
  assign occupancyO = occQ;

  always_ff @(posedge clkI or negedge rstNI) begin
    if (!rstNI) begin
      for (int i = 0; i < Depth; i++) begin
        memQ[i] <= '0;
      end
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      occQ   <= '0;
    end else begin
      if (wrEn) begin
        memQ[wrPtrQ] <= pushDataI;
        wrPtrQ       <= wrPtrQ + PtrW'(1);
      end
      if (rdEn) begin
        rdPtrQ <= rdPtrQ + PtrW'(1);
      end
      if (wrEn && !rdEn) begin
        occQ <= occQ + OccW'(1);
      end else if (!wrEn && rdEn) begin
        occQ <= occQ - OccW'(1);
      end
    end
  end

endmodule

// File: rtl/reg_bank_scan_reader.sv
// Scans a run of bank registers over port B and streams (address, data) pairs out through a FIFO,
// keeping a running byte sum of what was delivered.
module reg_bank_scan_reader #(
  parameter int unsigned ADDR_W     = reg_bank_pkg::ADDR_W,
  parameter int unsigned DATA_W     = reg_bank_pkg::DATA_W,
  parameter int unsigned READ_LAT   = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              CLKB,
  input  logic              RSTN,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] addrB,
  input  logic [DATA_W-1:0] data_outB,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] sum
);

  import reg_bank_pkg::scanStateE;
  import reg_bank_pkg::StIdle;
  import reg_bank_pkg::StIssue;
  import reg_bank_pkg::StDrain;

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OccW = PtrW + 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + READ_LAT + 2) + 1;
  localparam int unsigned FifoW = DATA_W + ADDR_W;

  scanStateE stateQ, stateD;

  logic [ADDR_W-1:0] nextAddrQ;
  logic [ADDR_W:0]   issueLeftQ, outLeftQ;
  logic [DATA_W-1:0] sumQ;
  logic              doneQ;

  // Stage 0 is the cycle addrB presents the address; stage READ_LAT is the capture cycle.
  logic              pipeValidQ [READ_LAT+1];
  logic [ADDR_W-1:0] pipeAddrQ  [READ_LAT+1];

  logic              accept, xfer, lastXfer, lastIssue, issue;
  logic [CntW-1:0]   inFlight;
  logic [OccW-1:0]   fifoOcc;
  logic              fifoEmpty;
  logic [FifoW-1:0]  fifoData;

  assign accept    = start && (stateQ == StIdle);
  assign xfer      = out_valid && out_ready;
  assign lastXfer  = xfer && (outLeftQ == (ADDR_W+1)'(1));
  assign lastIssue = issue && (issueLeftQ == (ADDR_W+1)'(1));

  always_comb begin
    inFlight = '0;
    for (int i = 0; i <= READ_LAT; i++) begin
      inFlight = inFlight + CntW'(pipeValidQ[i]);
    end
  end

  // FSM: state register
  always_ff @(posedge CLKB or negedge RSTN) begin
    if (!RSTN) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  // FSM: next state
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle:  if (accept && (count != '0)) stateD = StIssue;
      StIssue: if (lastIssue) stateD = StDrain;
      StDrain: if (lastXfer) stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  // FSM: outputs; reserve FIFO space for every read already on its way.
  always_comb begin
    busy  = 1'b0;
    issue = 1'b0;
    unique case (stateQ)
      StIdle:  busy = 1'b0;
      StIssue: begin
        busy  = 1'b1;
        issue = ((CntW'(fifoOcc) + inFlight) < CntW'(FIFO_DEPTH));
      end
      StDrain: busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge CLKB or negedge RSTN) begin
    if (!RSTN) begin
      nextAddrQ  <= '0;
      issueLeftQ <= '0;
      outLeftQ   <= '0;
      sumQ       <= '0;
      doneQ      <= 1'b0;
    end else begin
      doneQ <= lastXfer || (accept && (count == '0));
      if (accept) begin
        nextAddrQ  <= base_addr;
        issueLeftQ <= count;
        outLeftQ   <= count;
        sumQ       <= '0;
      end else begin
        if (issue) begin
          nextAddrQ  <= nextAddrQ + ADDR_W'(1);
          issueLeftQ <= issueLeftQ - (ADDR_W+1)'(1);
        end
        if (xfer) begin
          outLeftQ <= outLeftQ - (ADDR_W+1)'(1);
          sumQ     <= sumQ + out_data;
        end
      end
    end
  end

  always_ff @(posedge CLKB or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i <= READ_LAT; i++) begin
        pipeValidQ[i] <= 1'b0;
        pipeAddrQ[i]  <= '0;
      end
    end else begin
      pipeValidQ[0] <= issue;
      if (issue) begin
        pipeAddrQ[0] <= nextAddrQ;
      end
      for (int i = 1; i <= READ_LAT; i++) begin
        pipeValidQ[i] <= pipeValidQ[i-1];
        pipeAddrQ[i]  <= pipeAddrQ[i-1];
      end
    end
  end

  reg_bank_out_fifo #(
    .Width (FifoW),
    .Depth (FIFO_DEPTH)
  ) uOutFifo (
    .clkI       (CLKB),
    .rstNI      (RSTN),
    .pushI      (pipeValidQ[READ_LAT]),
    .pushDataI  ({pipeAddrQ[READ_LAT], data_outB}),
    .popI       (xfer),
    .popDataO   (fifoData),
    .emptyO     (fifoEmpty),
    .occupancyO (fifoOcc)
  );

  assign addrB     = pipeAddrQ[0];
  assign out_valid = !fifoEmpty;
  assign out_addr  = fifoData[FifoW-1:DATA_W];
  assign out_data  = fifoData[DATA_W-1:0];
  assign done      = doneQ;
  assign sum       = sumQ;

endmodule

// File: tb/tb_reg_bank_scan_reader.sv
// Bench for reg_bank_scan_reader: a registered bank model (reg i = 8'h10+i) and a queue-based
// reference of the expected stream, sum, busy and done, checked every cycle.
module tb_reg_bank_scan_reader;

  logic       CLKB = 1'b0;
  logic       RSTN = 1'b1;
  logic       start = 1'b0;
  logic [3:0] base_addr = '0;
  logic [4:0] count = '0;
  logic [3:0] addrB;
  logic [7:0] data_outB = '0;
  logic [7:0] out_data;
  logic [3:0] out_addr;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       busy;
  logic       done;
  logic [7:0] sum;

  reg_bank_scan_reader #(
    .ADDR_W     (4),
    .DATA_W     (8),
    .READ_LAT   (1),
    .FIFO_DEPTH (4)
  ) dut (
    .CLKB      (CLKB),
    .RSTN      (RSTN),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .addrB     (addrB),
    .data_outB (data_outB),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .sum       (sum)
  );

  always #5 CLKB = ~CLKB;

  // Bank port B with one cycle of read latency.
  always @(posedge CLKB) data_outB <= 8'h10 + {4'h0, addrB};

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
  } entT;

  entT        q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         mLeft = 0;
  int         mXfers = 0;
  int         readyMode = 0;
  logic       mBusy = 1'b0;
  logic [7:0] mSum = '0;
  logic       stallPrev = 1'b0;
  logic [7:0] prevData = '0;
  logic [3:0] prevAddr = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic xfer, acc, doneNext;
    entT  e;
    unique case (readyMode)
      1:       out_ready = (cyc % 4 == 0);
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b1;
    endcase
    doneNext = 1'b0;
    if (q.size() == 0) chk("no_valid_when_nothing_pending", out_valid, 0);
    if (stallPrev) begin
      chk("stall_valid_held", out_valid, 1);
      chk("stall_data_stable", out_data, prevData);
      chk("stall_addr_stable", out_addr, prevAddr);
    end
    stallPrev = out_valid && !out_ready;
    prevData  = out_data;
    prevAddr  = out_addr;
    chk("no_overflow", (int'(dut.fifoOcc) + int'(dut.inFlight)) <= 4, 1);
    xfer = out_valid && out_ready;
    acc  = start && !mBusy;
    if (xfer && q.size() != 0) begin
      e = q.pop_front();
      chk("xfer_addr", out_addr, e.a);
      chk("xfer_data", out_data, e.d);
      mSum = mSum + e.d;
      mXfers++;
      mLeft--;
      if (mLeft == 0) begin
        mBusy    = 1'b0;
        doneNext = 1'b1;
      end
    end
    if (acc) begin
      mSum   = '0;
      mXfers = 0;
      if (count == 0) begin
        doneNext = 1'b1;
      end else begin
        mBusy = 1'b1;
        mLeft = int'(count);
        for (int k = 0; k < int'(count); k++) begin
          e.a = 4'(int'(base_addr) + k);
          e.d = 8'h10 + {4'h0, e.a};
          q.push_back(e);
        end
      end
    end
    @(posedge CLKB);
    #1;
    start = 1'b0;
    cyc++;
    chk("busy", busy, mBusy);
    chk("done", done, doneNext);
    chk("sum", sum, mSum);
  endtask

  task automatic launch(input logic [3:0] b, input logic [4:0] c);
    base_addr = b;
    count     = c;
    start     = 1'b1;
    tick();
  endtask

  task automatic waitIdle(input int bound);
    int n = 0;
    while ((mBusy || q.size() != 0) && n < bound) begin
      tick();
      n++;
    end
    chk("scan_completes_in_budget", n < bound, 1);
  endtask

  task automatic applyReset();
    RSTN  = 1'b0;
    start = 1'b0;
    #1;
    chk("rst_addrB", addrB, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    q.delete();
    mBusy     = 1'b0;
    mSum      = '0;
    mLeft     = 0;
    stallPrev = 1'b0;
    @(posedge CLKB);
    #1;
    @(posedge CLKB);
    #1;
    RSTN = 1'b1;
  endtask

  initial begin
    #2;
    applyReset();
    tick();
    tick();

    // Full scan of all 16 registers.
    launch(4'd0, 5'd16);
    waitIdle(200);
    chk("full_sum", sum, 8'h78);
    chk("full_xfers", mXfers, 16);
    tick();

    // Address wrap 14, 15, 0, 1.
    launch(4'd14, 5'd4);
    waitIdle(100);
    chk("wrap_sum", sum, 8'h5E);
    tick();

    // Backpressure: ready one cycle in four.
    readyMode = 1;
    launch(4'd0, 5'd16);
    waitIdle(400);
    chk("bp_sum", sum, 8'h78);
    chk("bp_xfers", mXfers, 16);
    readyMode = 0;
    tick();

    // count=0: done next cycle, no busy, no data.
    launch(4'd5, 5'd0);
    chk("cnt0_busy", busy, 0);
    chk("cnt0_valid", out_valid, 0);
    tick();
    tick();

    // Start while busy is ignored; start in the done cycle is accepted.
    launch(4'd0, 5'd4);
    tick();
    base_addr = 4'd8;
    count     = 5'd2;
    start     = 1'b1;
    tick();
    waitIdle(100);
    chk("busy_start_sum", sum, 8'h46);
    launch(4'd3, 5'd2);
    waitIdle(100);
    chk("done_cycle_start_sum", sum, 8'h27);
    tick();

    // Reset after 5 transfers of a 16-register scan.
    launch(4'd0, 5'd16);
    for (int n = 0; n < 200 && mXfers < 5; n++) tick();
    chk("pre_reset_xfers", mXfers, 5);
    applyReset();
    repeat (3) tick();
    launch(4'd3, 5'd2);
    waitIdle(100);
    chk("post_reset_sum", sum, 8'h27);
    tick();

    // Randomized scans with random backpressure.
    for (int r = 0; r < 10; r++) begin
      readyMode = (r % 2 == 0) ? 2 : 0;
      launch(4'($urandom_range(0, 15)), 5'($urandom_range(0, 16)));
      waitIdle(600);
      if ($urandom_range(0, 1) == 1) tick();
    end
    readyMode = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
